// File: rtl/adder_pkg.sv
// Shared types and helpers for the multi-cycle adder.
package adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r = r + 1;
        return r;
    endfunction

endpackage

// File: rtl/chunk_adder.sv
// Combinational CHUNK-bit adder with carry-in and carry-out.
module chunk_adder #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co
);

    assign {co, s} = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

endmodule

// File: rtl/multi_cycle_adder.sv
// WIDTH-bit adder that processes CHUNK bits per clock through a registered carry,
// with a start/busy/done handshake.
module multi_cycle_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Overflow
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (clog2(N) < 1) ? 1 : clog2(N);

    generate
        if (CHUNK < 1) begin : g_bad_chunk
            $fatal(1, "multi_cycle_adder: CHUNK must be at least 1");
        end else if ((WIDTH % CHUNK) != 0) begin : g_bad_width
            $fatal(1, "multi_cycle_adder: WIDTH must be a multiple of CHUNK");
        end
    endgenerate

    state_t           state, state_next;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr, res_next;
    logic             carry, a_msb, b_msb;
    logic [IDX_W-1:0] idx;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_co;
    logic             accept, last;

    chunk_adder #(.CHUNK(CHUNK)) u_chunk (
        .a  (a_sr[CHUNK-1:0]),
        .b  (b_sr[CHUNK-1:0]),
        .ci (carry),
        .s  (chunk_s),
        .co (chunk_co)
    );

    // Each new chunk enters the result from the top, so after N steps it is aligned.
    generate
        if (N == 1) begin : g_single
            assign res_next = chunk_s;
        end else begin : g_multi
            assign res_next = {chunk_s, res_sr[WIDTH-1:CHUNK]};
        end
    endgenerate

    always_comb begin
        state_next = state;
        accept     = start && ((state == IDLE) || (state == DONE));
        last       = (idx == IDX_W'(N - 1));
        busy       = (state == RUN);
        done       = (state == DONE);
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            idx      <= '0;
            carry    <= 1'b0;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            Sum      <= '0;
            Cout     <= 1'b0;
            Overflow <= 1'b0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_sr  <= A;
                b_sr  <= B;
                a_msb <= A[WIDTH-1];
                b_msb <= B[WIDTH-1];
                carry <= Cin;
                idx   <= '0;
            end else if (state == RUN) begin
                a_sr   <= a_sr >> CHUNK;
                b_sr   <= b_sr >> CHUNK;
                carry  <= chunk_co;
                res_sr <= res_next;
                idx    <= idx + IDX_W'(1);
                // Outputs only move on the final chunk; they hold otherwise.
                if (last) begin
                    Sum      <= res_next;
                    Cout     <= chunk_co;
                    Overflow <= (a_msb == b_msb) && (res_next[WIDTH-1] != a_msb);
                end
            end
        end
    end

endmodule

// File: tb/tb_multi_cycle_adder.sv
// Scoreboard bench: drivers push expected results, per-DUT monitors pop on done.
module tb_multi_cycle_adder;

    typedef struct {
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    logic        start_m = 1'b0, cin_m = 1'b0, busy_m, done_m, cout_m, ovf_m;
    logic [15:0] a_m = '0, b_m = '0, sum_m;
    logic        start_p = 1'b0, cin_p = 1'b0, busy_p, done_p, cout_p, ovf_p;
    logic [7:0]  a_p = '0, b_p = '0, sum_p;
    logic        start_q = 1'b0, cin_q = 1'b0, busy_q, done_q, cout_q, ovf_q;
    logic [7:0]  a_q = '0, b_q = '0, sum_q;

    exp_t q_m[$];
    exp_t q_p[$];
    exp_t q_q[$];

    multi_cycle_adder #(.WIDTH(16), .CHUNK(4)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .A(a_m), .B(b_m), .Cin(cin_m),
        .busy(busy_m), .done(done_m), .Sum(sum_m), .Cout(cout_m), .Overflow(ovf_m)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(1)) dut_p (
        .clk(clk), .rst(rst), .start(start_p), .A(a_p), .B(b_p), .Cin(cin_p),
        .busy(busy_p), .done(done_p), .Sum(sum_p), .Cout(cout_p), .Overflow(ovf_p)
    );

    multi_cycle_adder #(.WIDTH(8), .CHUNK(8)) dut_q (
        .clk(clk), .rst(rst), .start(start_q), .A(a_q), .B(b_q), .Cin(cin_q),
        .busy(busy_q), .done(done_q), .Sum(sum_q), .Cout(cout_q), .Overflow(ovf_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic check_result(input string tag, input exp_t e, input logic [15:0] s,
                                input logic co, input logic ov);
        check_output({tag, "_sum"},   32'(s),  32'(e.sum));
        check_output({tag, "_cout"},  32'(co), 32'(e.cout));
        check_output({tag, "_ovf"},   32'(ov), 32'(e.ovf));
        check_output({tag, "_cycle"}, cyc,     e.cyc);
    endtask

    // Reference arithmetic for random vectors.
    function automatic exp_t model(input int w, input logic [15:0] a, input logic [15:0] b,
                                   input logic cin);
        exp_t        e;
        logic [16:0] full;
        logic [15:0] mask;
        mask   = (w == 16) ? 16'hFFFF : 16'h00FF;
        full   = {1'b0, a & mask} + {1'b0, b & mask} + 17'(cin);
        e.sum  = full[15:0] & mask;
        e.cout = full[w];
        e.ovf  = (a[w-1] == b[w-1]) && (e.sum[w-1] != a[w-1]);
        e.cyc  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done_m === 1'b1) begin
            if (q_m.size() == 0) check_output("m_unexpected_done", 32'd1, 32'd0);
            else check_result("m", q_m.pop_front(), sum_m, cout_m, ovf_m);
        end
    end

    always @(negedge clk) begin
        if (done_p === 1'b1) begin
            if (q_p.size() == 0) check_output("p_unexpected_done", 32'd1, 32'd0);
            else check_result("p", q_p.pop_front(), {8'h00, sum_p}, cout_p, ovf_p);
        end
    end

    always @(negedge clk) begin
        if (done_q === 1'b1) begin
            if (q_q.size() == 0) check_output("q_unexpected_done", 32'd1, 32'd0);
            else check_result("q", q_q.pop_front(), {8'h00, sum_q}, cout_q, ovf_q);
        end
    end

    function automatic int qsize(input int sel);
        case (sel)
            0:       return q_m.size();
            1:       return q_p.size();
            default: return q_q.size();
        endcase
    endfunction

    task automatic wait_drain(input int sel, input int budget);
        int k;
        k = 0;
        while (qsize(sel) != 0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (qsize(sel) != 0) begin
            check_output("drain_timeout", 32'(qsize(sel)), 32'd0);
            case (sel)
                0:       q_m.delete();
                1:       q_p.delete();
                default: q_q.delete();
            endcase
        end
    endtask

    // Launch one add on the 16/4 instance; done is due N=4 edges after the accepting edge.
    task automatic apply_stimulus(input logic [15:0] a, input logic [15:0] b, input logic cin,
                                  input logic [15:0] esum, input logic ecout, input logic eovf);
        exp_t e;
        @(negedge clk);
        a_m     = a;
        b_m     = b;
        cin_m   = cin;
        start_m = 1'b1;
        e.sum   = esum;
        e.cout  = ecout;
        e.ovf   = eovf;
        e.cyc   = cyc + 1 + 4;
        q_m.push_back(e);
        @(negedge clk);
        start_m = 1'b0;
    endtask

    task automatic drive_random(input int sel, input int count);
        for (int i = 0; i < count; i++) begin
            logic [15:0] ra, rb;
            logic        rc;
            exp_t        e;
            int          n;
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom_range(0, 1));
            n  = (sel == 0) ? 4 : (sel == 1) ? 8 : 1;
            @(negedge clk);
            e     = model((sel == 0) ? 16 : 8, ra, rb, rc);
            e.cyc = cyc + 1 + n;
            case (sel)
                0: begin a_m = ra; b_m = rb; cin_m = rc; start_m = 1'b1; q_m.push_back(e); end
                1: begin a_p = ra[7:0]; b_p = rb[7:0]; cin_p = rc; start_p = 1'b1; q_p.push_back(e); end
                default: begin a_q = ra[7:0]; b_q = rb[7:0]; cin_q = rc; start_q = 1'b1; q_q.push_back(e); end
            endcase
            @(negedge clk);
            start_m = 1'b0;
            start_p = 1'b0;
            start_q = 1'b0;
            wait_drain(sel, n + 6);
        end
    endtask

    initial begin
        int   cnt;
        int   k;
        exp_t e;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_output("rst_busy", 32'(busy_m), 32'd0);
        check_output("rst_done", 32'(done_m), 32'd0);
        check_output("rst_sum",  32'(sum_m),  32'd0);
        check_output("rst_cout", 32'(cout_m), 32'd0);
        check_output("rst_ovf",  32'(ovf_m),  32'd0);
        rst = 1'b0;
        @(negedge clk);
        check_output("post_rst_done", 32'(done_m), 32'd0);

        $display("[TB] carry ripple through all chunks");
        apply_stimulus(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        cnt = 0;
        k   = 0;
        while (done_m !== 1'b1 && k < 20) begin
            if (busy_m === 1'b1) cnt++;
            @(negedge clk);
            k++;
        end
        check_output("busy_cycles", cnt, 4);
        wait_drain(0, 10);

        $display("[TB] overflow boundaries");
        apply_stimulus(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        wait_drain(0, 10);
        apply_stimulus(16'hFFFF, 16'h8000, 1'b1, 16'h8000, 1'b1, 1'b0);
        wait_drain(0, 10);

        $display("[TB] operand capture and result hold");
        apply_stimulus(16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
        a_m   = 16'h0000;
        b_m   = 16'h0000;
        cin_m = 1'b0;
        check_output("hold_sum",  32'(sum_m),  32'h8000);
        check_output("hold_cout", 32'(cout_m), 32'd1);
        wait_drain(0, 10);

        $display("[TB] start during run ignored, start held in done");
        apply_stimulus(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0);
        start_m = 1'b1;
        @(negedge clk);
        start_m = 1'b0;
        a_m     = 16'h5000;
        b_m     = 16'h5000;
        cin_m   = 1'b0;
        start_m = 1'b1;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (done_m !== 1'b1 && k < 20);
        if (done_m !== 1'b1) check_output("first_done_timeout", 32'(done_m), 32'd1);
        e.sum  = 16'hA000;
        e.cout = 1'b0;
        e.ovf  = 1'b1;
        e.cyc  = cyc + 1 + 4;
        q_m.push_back(e);
        @(negedge clk);
        start_m = 1'b0;
        wait_drain(0, 12);

        $display("[TB] reset in the middle of a run");
        apply_stimulus(16'h0003, 16'h0004, 1'b0, 16'h0007, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        q_m.delete();
        @(negedge clk);
        rst = 1'b0;
        check_output("midrst_busy", 32'(busy_m), 32'd0);
        check_output("midrst_done", 32'(done_m), 32'd0);
        check_output("midrst_sum",  32'(sum_m),  32'd0);
        check_output("midrst_cout", 32'(cout_m), 32'd0);
        apply_stimulus(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0);
        wait_drain(0, 10);

        $display("[TB] random vectors on three configurations");
        drive_random(0, 1000);
        drive_random(1, 1000);
        drive_random(2, 1000);

        repeat (3) @(negedge clk);
        check_output("leftover_m", 32'(q_m.size()), 32'd0);
        check_output("leftover_p", 32'(q_p.size()), 32'd0);
        check_output("leftover_q", 32'(q_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
